fp_norm_shifter: RTL and testbench



---
 rtl/fp_norm_shifter.sv | 104 ++++++++++
 tb/tb_fp_norm_shifter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_norm_shifter.sv
// Iterative significand normaliser: shifts left one bit per clock until the hidden
// bit is set, stopping early on a zero significand or exponent underflow.
module fp_norm_shifter #(
    parameter int MW = 24,
    parameter int EW = 8,
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          res_n,
    input  logic          start,
    input  logic [MW-1:0] mant_in,
    input  logic [EW-1:0] exp_in,
    output logic          busy,
    output logic          done,
    output logic [MW-1:0] mant_out,
    output logic [EW-1:0] exp_out,
    output logic [CW-1:0] shift_cnt,
    output logic          zero,
    output logic          denorm
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [MW-1:0] m_reg, m_next;
    logic [EW-1:0] e_reg, e_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          zero_reg, zero_next;
    logic          denorm_reg, denorm_next;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_reg  <= IDLE;
            m_reg      <= '0;
            e_reg      <= '0;
            cnt_reg    <= '0;
            zero_reg   <= 1'b0;
            denorm_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            m_reg      <= m_next;
            e_reg      <= e_next;
            cnt_reg    <= cnt_next;
            zero_reg   <= zero_next;
            denorm_reg <= denorm_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        m_next      = m_reg;
        e_next      = e_reg;
        cnt_next    = cnt_reg;
        zero_next   = zero_reg;
        denorm_next = denorm_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    m_next      = mant_in;
                    e_next      = exp_in;
                    cnt_next    = '0;
                    zero_next   = 1'b0;
                    denorm_next = 1'b0;
                    state_next  = SHIFT;
                end else begin
                    state_next  = IDLE;
                end
            end
            SHIFT: begin
                // Rule order matters: a set MSB wins over a small exponent, so
                // exp_in=0 with the hidden bit set comes out as a normal result.
                if (m_reg == '0) begin
                    zero_next  = 1'b1;
                    e_next     = '0;
                    state_next = DONE;
                end else if (m_reg[MW-1]) begin
                    state_next = DONE;
                end else if (e_reg <= EW'(1)) begin
                    denorm_next = 1'b1;
                    e_next      = '0;
                    state_next  = DONE;
                end else begin
                    m_next   = {m_reg[MW-2:0], 1'b0};
                    e_next   = e_reg - EW'(1);
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state_reg == SHIFT);
    assign done      = (state_reg == DONE);
    assign mant_out  = m_reg;
    assign exp_out   = e_reg;
    assign shift_cnt = cnt_reg;
    assign zero      = zero_reg;
    assign denorm    = denorm_reg;

endmodule

// File: tb/tb_fp_norm_shifter.sv
// Bench for fp_norm_shifter: directed and random jobs against a leading-zero based
// reference model, plus reset, busy-start and back-to-back handshake scenarios.
module tb_fp_norm_shifter;

    logic        clk = 1'b0;
    logic        res_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] mant_in = '0;
    logic [7:0]  exp_in = '0;
    logic        busy, done, zero, denorm;
    logic [23:0] mant_out;
    logic [7:0]  exp_out;
    logic [5:0]  shift_cnt;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    fp_norm_shifter #(.MW(24), .EW(8), .CW(6)) dut (
        .clk(clk), .res_n(res_n), .start(start), .mant_in(mant_in), .exp_in(exp_in),
        .busy(busy), .done(done), .mant_out(mant_out), .exp_out(exp_out),
        .shift_cnt(shift_cnt), .zero(zero), .denorm(denorm)
    );

    // Packed result {mant, exp, cnt, zero, denorm} derived from the leading-zero count.
    function automatic logic [39:0] ref_model(input logic [23:0] mi, input logic [7:0] ei);
        int lz;
        int k;
        if (mi == 24'd0) return {24'd0, 8'd0, 6'd0, 1'b1, 1'b0};
        lz = 0;
        while (mi[23-lz] == 1'b0) lz++;
        if (lz == 0) return {mi, ei, 6'd0, 1'b0, 1'b0};
        if (ei <= 8'd1) return {mi, 8'd0, 6'd0, 1'b0, 1'b1};
        k = int'(ei) - 1;
        if (lz <= k) return {24'(mi << lz), 8'(int'(ei) - lz), 6'(lz), 1'b0, 1'b0};
        return {24'(mi << k), 8'd0, 6'(k), 1'b0, 1'b1};
    endfunction

    function automatic logic [39:0] observed();
        return {mant_out, exp_out, shift_cnt, zero, denorm};
    endfunction

    // Called #1 after a rising edge; returns in the done cycle (or on timeout).
    // cyc counts cycles with the start cycle as 0, so done is expected at k+2.
    task automatic run_job(input logic [23:0] mi, input logic [7:0] ei,
                           output int cyc, output int bcyc);
        start = 1'b1; mant_in = mi; exp_in = ei;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; bcyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) bcyc++;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({busy, done, observed()} !== 42'd0) begin
            errors++;
            $display("FAIL reset_state: got %h required 0", {busy, done, observed()});
        end
        repeat (3) @(posedge clk);
        #1 res_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({busy, done, observed()} !== 42'd0) begin
            errors++;
            $display("FAIL reset_release: got %h required 0", {busy, done, observed()});
        end
    endtask

    task automatic test_directed();
        logic [23:0] mt [5] = '{24'h800000, 24'h000001, 24'h000000, 24'h000100, 24'h800001};
        logic [7:0]  et [5] = '{8'h80, 8'h80, 8'h55, 8'h03, 8'h00};
        logic [39:0] exp_r;
        int cyc, bcyc;
        for (int i = 0; i < 5; i++) begin
            exp_r = ref_model(mt[i], et[i]);
            run_job(mt[i], et[i], cyc, bcyc);
            $display("directed %0d: mant_in=%h exp_in=%h -> mant=%h exp=%h cnt=%0d z=%b d=%b cyc=%0d",
                     i, mt[i], et[i], mant_out, exp_out, shift_cnt, zero, denorm, cyc);
            vectors++;
            if (observed() !== exp_r) begin
                errors++;
                $display("FAIL directed_result[%0d]: got %h required %h", i, observed(), exp_r);
            end
            vectors++;
            if (cyc != int'(exp_r[7:2]) + 2 || bcyc != int'(exp_r[7:2]) + 1) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got done@%0d busy=%0d required done@%0d busy=%0d",
                         i, cyc, bcyc, int'(exp_r[7:2]) + 2, int'(exp_r[7:2]) + 1);
            end
            @(posedge clk); #1;
            vectors++;
            if (done !== 1'b0 || observed() !== exp_r) begin
                errors++;
                $display("FAIL directed_hold[%0d]: got done=%b res=%h required done=0 res=%h",
                         i, done, observed(), exp_r);
            end
        end
    endtask

    task automatic test_random();
        logic [23:0] mi, top;
        logic [7:0]  ei;
        logic [39:0] exp_r;
        int r, cyc, bcyc;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 24);
            top = 24'h800000 >> r;
            mi = (r == 24) ? 24'd0 : (top | (24'($urandom) & (top - 24'd1)));
            ei = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 30)) : 8'($urandom);
            exp_r = ref_model(mi, ei);
            run_job(mi, ei, cyc, bcyc);
            $display("random %0d: mant_in=%h exp_in=%h -> mant=%h exp=%h cnt=%0d z=%b d=%b cyc=%0d",
                     i, mi, ei, mant_out, exp_out, shift_cnt, zero, denorm, cyc);
            vectors++;
            if (observed() !== exp_r || cyc != int'(exp_r[7:2]) + 2) begin
                errors++;
                $display("FAIL random[%0d]: got %h done@%0d required %h done@%0d",
                         i, observed(), cyc, exp_r, int'(exp_r[7:2]) + 2);
            end
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_busy_start();
        logic [39:0] exp_r;
        int cyc;
        exp_r = ref_model(24'h000001, 8'h80);
        start = 1'b1; mant_in = 24'h000001; exp_in = 8'h80;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        repeat (4) begin @(posedge clk); #1; cyc++; end
        start = 1'b1; mant_in = 24'h400000; exp_in = 8'h10;
        @(posedge clk); #1; cyc++;
        start = 1'b0;
        while (done !== 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
        $display("busy_start: mant=%h exp=%h cnt=%0d cyc=%0d", mant_out, exp_out, shift_cnt, cyc);
        vectors++;
        if (observed() !== exp_r || cyc != 25) begin
            errors++;
            $display("FAIL busy_start: got %h done@%0d required %h done@25", observed(), cyc, exp_r);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [23:0] mt [3] = '{24'h000030, 24'h7FFFFF, 24'h000002};
        logic [7:0]  et [3] = '{8'h20, 8'h02, 8'h05};
        logic [39:0] exp_r;
        int cyc, bcyc;
        for (int i = 0; i < 3; i++) begin
            exp_r = ref_model(mt[i], et[i]);
            run_job(mt[i], et[i], cyc, bcyc);
            $display("back_to_back %0d: mant=%h exp=%h cnt=%0d z=%b d=%b cyc=%0d",
                     i, mant_out, exp_out, shift_cnt, zero, denorm, cyc);
            vectors++;
            if (observed() !== exp_r || cyc != int'(exp_r[7:2]) + 2) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %h done@%0d required %h done@%0d",
                         i, observed(), cyc, exp_r, int'(exp_r[7:2]) + 2);
            end
        end
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_tail: got done=%b busy=%b required 0 0", done, busy);
        end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; mant_in = 24'h000004; exp_in = 8'h40;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 res_n = 1'b0;
        #1;
        $display("reset_mid: busy=%b done=%b res=%h", busy, done, observed());
        vectors++;
        if ({busy, done, observed()} !== 42'd0) begin
            errors++;
            $display("FAIL reset_mid: got %h required 0", {busy, done, observed()});
        end
        @(posedge clk); #1 res_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if ({busy, done, observed()} !== 42'd0) begin
            errors++;
            $display("FAIL reset_mid_release: got %h required 0", {busy, done, observed()});
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_start();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_directed();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
